imm_prefix_ctrl: RTL and testbench

Sequencer for the decode-stage immediate path. It accepts 8-bit immediate bytes one at a time over a valid/ready handshake and assembles them MSB-first into a 24-bit operand. The first byte is sign- or zero-extended to 24 bits; each following byte shifts in below it. One assembled operand at a time is presented to the execute-stage operand mux, so single-byte immediates and prefixed 16/24-bit constants share the one extension datapath.

---
 rtl/risc_pkg.sv | 12 +
 rtl/imm_prefix_ctrl_if.sv | 21 ++
 rtl/imm_byte_ext.sv | 14 +
 rtl/imm_prefix_ctrl.sv | 81 ++++++++
 tb/tb_imm_prefix_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared decode-stage constants and the immediate-sequencer state type.
package risc_pkg;
    localparam int IMM_DW   = 24;
    localparam int IMM_BW   = 8;
    localparam int IMM_MAXB = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } imm_st_t;
endpackage

// File: rtl/imm_prefix_ctrl_if.sv
// Byte-in / operand-out handshake bundle between decode and the immediate sequencer.
interface imm_prefix_ctrl_if;
    logic                         in_valid;
    logic                         in_ready;
    logic [risc_pkg::IMM_BW-1:0]  in_byte;
    logic                         in_more;
    logic                         in_zext;
    logic                         out_valid;
    logic                         out_ready;
    logic [risc_pkg::IMM_DW-1:0]  out_imm;
    logic                         out_err;

    modport master (
        output in_valid, in_byte, in_more, in_zext, out_ready,
        input  in_ready, out_valid, out_imm, out_err
    );
    modport slave (
        input  in_valid, in_byte, in_more, in_zext, out_ready,
        output in_ready, out_valid, out_imm, out_err
    );
endinterface

// File: rtl/imm_byte_ext.sv
// Widens one immediate byte to operand width, sign- or zero-extended.
module imm_byte_ext
    import risc_pkg::*;
#(
    parameter int DW = IMM_DW,
    parameter int BW = IMM_BW
) (
    input  logic [BW-1:0] data,
    input  logic          zext,
    output logic [DW-1:0] ext
);
    assign ext = zext ? {{(DW-BW){1'b0}}, data}
                      : {{(DW-BW){data[BW-1]}}, data};
endmodule

// File: rtl/imm_prefix_ctrl.sv
// Assembles MSB-first immediate bytes into one operand and presents it to execute.
module imm_prefix_ctrl
    import risc_pkg::*;
#(
    parameter int DW   = IMM_DW,
    parameter int BW   = IMM_BW,
    parameter int MAXB = IMM_MAXB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    imm_prefix_ctrl_if.slave bus
);
    localparam int CW = $clog2(MAXB + 1);

    imm_st_t       st;
    logic [DW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [DW-1:0] ext;
    logic [DW-1:0] nxt_acc;
    logic [CW-1:0] nxt_cnt;
    logic          accept;
    logic          drain;
    logic          first;
    logic          last;

    imm_byte_ext #(.DW(DW), .BW(BW)) u_ext (
        .data (bus.in_byte),
        .zext (bus.in_zext),
        .ext  (ext)
    );

    // No in_valid term here, so ready never depends on the producer.
    assign bus.in_ready = !flush && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = bus.out_valid && bus.out_ready;

    // Anything not mid-operand starts a fresh operand, including a HOLD drain.
    assign first   = (st != ACC);
    assign nxt_acc = first ? ext : {acc[DW-BW-1:0], bus.in_byte};
    assign nxt_cnt = first ? CW'(1) : cnt + CW'(1);
    assign last    = !bus.in_more || (nxt_cnt == CW'(MAXB));

    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_imm   <= '0;
            bus.out_err   <= 1'b0;
        end else if (flush) begin
            st            <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_imm   <= '0;
            bus.out_err   <= 1'b0;
        end else if (accept) begin
            acc <= nxt_acc;
            if (last) begin
                // Overlength shows up as a third byte still claiming more.
                st            <= HOLD;
                cnt           <= '0;
                bus.out_valid <= 1'b1;
                bus.out_imm   <= nxt_acc;
                bus.out_err   <= bus.in_more;
            end else begin
                st            <= ACC;
                cnt           <= nxt_cnt;
                bus.out_valid <= 1'b0;
                bus.out_err   <= 1'b0;
            end
        end else if (drain) begin
            st            <= IDLE;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_err   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imm_prefix_ctrl.sv
// Vector table, reset/flush corner case and random traffic against an operand-level model.
module tb_imm_prefix_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks   = 0;
    int   failures = 0;

    imm_prefix_ctrl_if bus ();

    imm_prefix_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [7:0]  b;
        logic        more;
        logic        zext;
        logic        ordy;
        logic        fl;
        logic        e_rdy;
        logic        e_ov;
        logic [23:0] e_imm;
        logic        e_err;
    } vec_t;

    // Model: bytes of the partial operand plus what the output should show.
    logic [7:0]  part[$];
    logic        pz;
    logic        mv;
    logic [23:0] mimm;
    logic        merr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] build(input logic zx);
        logic [31:0] v;
        logic [31:0] ones;
        v = 0;
        ones = '1;
        foreach (part[i]) v = (v << 8) | {24'd0, part[i]};
        if (!zx && part[0][7]) v = v | (ones << (8 * part.size()));
        return v[23:0];
    endfunction

    function automatic logic model_rdy(input logic fl, input logic ordy);
        return !fl && (!mv || ordy);
    endfunction

    task automatic model_step(input logic v, input logic [7:0] b, input logic more,
                              input logic zx, input logic ordy, input logic fl);
        logic acc_ok;
        acc_ok = v && model_rdy(fl, ordy);
        if (fl) begin
            mv = 0; merr = 0; mimm = 0;
            part.delete();
        end else begin
            if (mv && ordy) begin mv = 0; merr = 0; end
            if (acc_ok) begin
                if (part.size() == 0) pz = zx;
                part.push_back(b);
                if (!more || part.size() == 3) begin
                    mv = 1; mimm = build(pz); merr = more;
                    part.delete();
                end
            end
        end
    endtask

    // Drives one cycle, checks ready before the edge and outputs after it.
    task automatic cyc(input logic v, input logic [7:0] b, input logic more,
                       input logic zx, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_byte   = b;
        bus.in_more   = more;
        bus.in_zext   = zx;
        bus.out_ready = ordy;
        flush         = fl;
        #2;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, model_rdy(fl, ordy)});
        model_step(v, b, more, zx, ordy, fl);
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mv});
        if (mv) begin
            chk("out_imm", {8'd0, bus.out_imm}, {8'd0, mimm});
            chk("out_err", {31'd0, bus.out_err}, {31'd0, merr});
        end
    endtask

    vec_t tbl[18];

    initial begin
        //             vld  byte   more zx  ordy fl   rdy  ov   imm          err
        tbl[0]  = '{1'b1, 8'h85, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'hFFFF85, 1'b0};
        tbl[1]  = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0};
        tbl[2]  = '{1'b1, 8'h34, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0};
        tbl[3]  = '{1'b1, 8'h56, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h123456, 1'b0};
        tbl[4]  = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000080, 1'b0};
        tbl[5]  = '{1'b1, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0};
        tbl[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'hFFF001, 1'b0};
        tbl[7]  = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'hFFF001, 1'b0};
        tbl[8]  = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'hFFF001, 1'b0};
        tbl[9]  = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'hFFF001, 1'b0};
        tbl[10] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0};
        tbl[11] = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0};
        tbl[12] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h010203, 1'b1};
        tbl[13] = '{1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h00007F, 1'b0};
        tbl[14] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0};
        tbl[15] = '{1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0};
        tbl[16] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000005, 1'b0};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0};

        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 0; bus.in_byte = 0; bus.in_more = 0; bus.in_zext = 0; bus.out_ready = 0;
        mv = 0; mimm = 0; merr = 0; pz = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_imm", {8'd0, bus.out_imm}, 32'd0);
        chk("rst_out_err", {31'd0, bus.out_err}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 18; i++) begin
            bus.in_valid = tbl[i].vld; bus.in_byte = tbl[i].b; bus.in_more = tbl[i].more;
            bus.in_zext = tbl[i].zext; bus.out_ready = tbl[i].ordy; flush = tbl[i].fl;
            #2;
            chk($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].e_rdy});
            model_step(tbl[i].vld, tbl[i].b, tbl[i].more, tbl[i].zext, tbl[i].ordy, tbl[i].fl);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].e_ov});
            if (tbl[i].e_ov) begin
                chk($sformatf("vec%0d_out_imm", i), {8'd0, bus.out_imm}, {8'd0, tbl[i].e_imm});
                chk($sformatf("vec%0d_out_err", i), {31'd0, bus.out_err}, {31'd0, tbl[i].e_err});
            end
        end

        // Reset together with flush while an operand is held.
        cyc(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_imm", {8'd0, bus.out_imm}, 32'h000042);
        bus.in_valid = 1'b1; bus.in_byte = 8'h11; bus.in_more = 1'b1; bus.out_ready = 1'b0;
        rst = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
        mv = 0; mimm = 0; merr = 0; part.delete();
        #1;
        chk("rstflush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rstflush_out_imm", {8'd0, bus.out_imm}, 32'd0);
        chk("rstflush_out_err", {31'd0, bus.out_err}, 32'd0);
        chk("rstflush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        // A byte after reset must start a fresh operand.
        cyc(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("post_rst_imm", {8'd0, bus.out_imm}, 32'h0000C3);

        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
